// File: rtl/seg_pkg.sv
// Shared types and glyph constants for the scanned 7-segment display.
package seg_pkg;

    typedef enum logic [0:0] {
        S_STATIC = 1'b0,
        S_ROT    = 1'b1
    } state_e;

    // Active-low {dp,g,f,e,d,c,b,a}; dp is always off.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low 7-segment glyph; non-decimal values show a dash.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [7:0] glyph_o
);

    // Blank overrides the nibble.
    always_comb begin
        glyph_o = SEG_DASH;
        if (blank_i) begin
            glyph_o = SEG_BLANK;
        end else begin
            case (nibble_i)
                4'd0:    glyph_o = SEG_0;
                4'd1:    glyph_o = SEG_1;
                4'd2:    glyph_o = SEG_2;
                4'd3:    glyph_o = SEG_3;
                4'd4:    glyph_o = SEG_4;
                4'd5:    glyph_o = SEG_5;
                4'd6:    glyph_o = SEG_6;
                4'd7:    glyph_o = SEG_7;
                4'd8:    glyph_o = SEG_8;
                4'd9:    glyph_o = SEG_9;
                default: glyph_o = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_disp.sv
// Multiplexed 8-digit display driver with edit-cursor blink and one-shot rotation.
module seg_scan_disp
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned STEP_DIV  = 16666666,
    parameter int unsigned BLINK_DIV = 12500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] disp_data,
    input  logic        disp_data_en,
    input  logic        edit_en,
    input  logic [3:0]  weishu,
    input  logic [3:0]  shuzi,
    output logic [7:0]  seg,
    output logic [7:0]  an,
    output logic        rot_busy
);

    localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned STEP_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [STEP_W-1:0]  STEP_MAX  = STEP_W'(STEP_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [2:0]         slot_q, slot_d;
    logic [2:0]         offset_q, offset_d;
    logic               blink_on_q, blink_on_d;
    logic               en_prev_q, en_prev_d;
    state_e             state_q, state_d;
    logic [31:0]        rot_buf_q, rot_buf_d;
    logic [7:0]         seg_q, seg_d;
    logic [7:0]         an_q, an_d;
    logic               rot_busy_q, rot_busy_d;

    logic               start;
    logic [2:0]         rot_idx;
    logic [3:0]         sel_nibble;
    logic               sel_blank;
    logic [7:0]         glyph;

    // Free-running scan and blink timebases plus the display-mode edge detector.
    always_comb begin
        scan_cnt_d  = (scan_cnt_q == SCAN_MAX) ? '0 : scan_cnt_q + 1'b1;
        slot_d      = (scan_cnt_q == SCAN_MAX) ? slot_q + 3'd1 : slot_q;
        blink_cnt_d = (blink_cnt_q == BLINK_MAX) ? '0 : blink_cnt_q + 1'b1;
        blink_on_d  = (blink_cnt_q == BLINK_MAX) ? ~blink_on_q : blink_on_q;
        en_prev_d   = disp_data_en;
        start       = disp_data_en & ~en_prev_q;
    end

    // Rotation FSM: snapshot on start, advance offset once per step, leave after 8 steps.
    always_comb begin
        state_d    = state_q;
        rot_buf_d  = rot_buf_q;
        offset_d   = offset_q;
        step_cnt_d = step_cnt_q;
        unique case (state_q)
            S_STATIC: begin
                if (start) begin
                    state_d    = S_ROT;
                    rot_buf_d  = disp_data;
                    offset_d   = 3'd0;
                    step_cnt_d = '0;
                end
            end
            S_ROT: begin
                if (step_cnt_q == STEP_MAX) begin
                    step_cnt_d = '0;
                    offset_d   = offset_q + 3'd1;
                    if (offset_q == 3'd7) begin
                        state_d = S_STATIC;
                    end
                end else begin
                    step_cnt_d = step_cnt_q + 1'b1;
                end
            end
            default: state_d = S_STATIC;
        endcase
        rot_busy_d = (state_d == S_ROT);
    end

    // Source selection for the current slot: rotated snapshot, cursor overlay or live data.
    always_comb begin
        rot_idx    = slot_q + offset_q;
        sel_blank  = 1'b0;
        sel_nibble = disp_data[{slot_q, 2'b00} +: 4];
        if (state_q == S_ROT) begin
            sel_nibble = rot_buf_q[{rot_idx, 2'b00} +: 4];
        end else if (edit_en && (weishu == {1'b0, slot_q})) begin
            sel_nibble = shuzi;
            sel_blank  = ~blink_on_q;
        end
    end

    seg7_decode u_decode (
        .nibble_i (sel_nibble),
        .blank_i  (sel_blank),
        .glyph_o  (glyph)
    );

    // Registered display outputs.
    always_comb begin
        seg_d = glyph;
        an_d  = ~(8'b1 << slot_q);
    end

    // All state, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q  <= '0;
            step_cnt_q  <= '0;
            blink_cnt_q <= '0;
            slot_q      <= 3'd0;
            offset_q    <= 3'd0;
            blink_on_q  <= 1'b1;
            en_prev_q   <= 1'b0;
            state_q     <= S_STATIC;
            rot_buf_q   <= '0;
            seg_q       <= SEG_BLANK;
            an_q        <= 8'hFF;
            rot_busy_q  <= 1'b0;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            step_cnt_q  <= step_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            slot_q      <= slot_d;
            offset_q    <= offset_d;
            blink_on_q  <= blink_on_d;
            en_prev_q   <= en_prev_d;
            state_q     <= state_d;
            rot_buf_q   <= rot_buf_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            rot_busy_q  <= rot_busy_d;
        end
    end

    assign seg      = seg_q;
    assign an       = an_q;
    assign rot_busy = rot_busy_q;

endmodule

// File: tb/tb_seg_scan_disp.sv
// Self-checking bench for seg_scan_disp with a time-indexed reference model.
module tb_seg_scan_disp;

    localparam int unsigned SCAN  = 4;
    localparam int unsigned STEP  = 40;
    localparam int unsigned BLINK = 20;
    localparam int          ROT_LEN = 8 * STEP;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] disp_data;
    logic        disp_data_en;
    logic        edit_en;
    logic [3:0]  weishu;
    logic [3:0]  shuzi;
    logic [7:0]  seg;
    logic [7:0]  an;
    logic        rot_busy;

    int checks = 0;
    int errors = 0;

    seg_scan_disp #(
        .SCAN_DIV  (SCAN),
        .STEP_DIV  (STEP),
        .BLINK_DIV (BLINK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .disp_data    (disp_data),
        .disp_data_en (disp_data_en),
        .edit_en      (edit_en),
        .weishu       (weishu),
        .shuzi        (shuzi),
        .seg          (seg),
        .an           (an),
        .rot_busy     (rot_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] glyph(input int v);
        case (v)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            10, 11, 12, 13, 14, 15: return 8'hBF;
            default: return 8'hFF;
        endcase
    endfunction

    // Model: n = clock edges since reset released; rotation started after edge rot_m.
    int          n = 0;
    int          rot_m = 0;
    bit          rot_active = 0;
    bit          en_prev = 0;
    logic [31:0] snap = '0;
    logic [7:0]  exp_seg = 8'hFF;
    logic [7:0]  exp_an = 8'hFF;
    logic        exp_busy = 1'b0;

    always @(posedge clk) begin
        int  slot;
        int  val;
        bit  rotating;
        if (rst) begin
            n          = 0;
            rot_active = 0;
            en_prev    = 0;
            exp_seg    = 8'hFF;
            exp_an     = 8'hFF;
            exp_busy   = 1'b0;
        end else begin
            slot     = (n / SCAN) % 8;
            rotating = rot_active && ((n - rot_m) < ROT_LEN);
            exp_an   = ~(8'b1 << slot);
            if (rotating) begin
                val = int'(snap[((slot + (n - rot_m) / STEP) % 8) * 4 +: 4]);
            end else if (edit_en && (int'(weishu) == slot)) begin
                val = (((n / BLINK) % 2) == 0) ? int'(shuzi) : -1;
            end else begin
                val = int'(disp_data[slot * 4 +: 4]);
            end
            exp_seg = glyph(val);
            if (!rotating && disp_data_en && !en_prev) begin
                rot_active = 1;
                rot_m      = n + 1;
                snap       = disp_data;
            end
            en_prev  = disp_data_en;
            n        = n + 1;
            exp_busy = rot_active && ((n - rot_m) < ROT_LEN);
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        chk("seg", seg, exp_seg);
        chk("an", an, exp_an);
        chk("rot_busy", {7'b0, rot_busy}, {7'b0, exp_busy});
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    initial begin
        int busy_cnt;
        int hold;

        rst          = 1'b1;
        disp_data    = 32'h7654_3210;
        disp_data_en = 1'b0;
        edit_en      = 1'b0;
        weishu       = 4'd0;
        shuzi        = 4'd0;
        run(3);
        chk("reset_seg", seg, 8'hFF);
        chk("reset_an", an, 8'hFF);

        // Plain scan of 0..7.
        rst = 1'b0;
        step();
        chk("first_an", an, 8'hFE);
        chk("first_seg", seg, 8'hC0);
        run(40);

        // Non-decimal nibbles render as dashes.
        disp_data = 32'hFA00_0000;
        run(36);

        // Cursor overlay blinks; out-of-range cursor has no overlay.
        edit_en = 1'b1;
        weishu  = 4'd3;
        shuzi   = 4'd9;
        run(90);
        weishu = 4'd9;
        run(36);
        edit_en = 1'b0;

        // Rotation with snapshot, length measured directly.
        disp_data    = 32'h7654_3210;
        disp_data_en = 1'b1;
        busy_cnt     = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (rot_busy) busy_cnt++;
            if (i == 1) begin
                disp_data_en = 1'b0;
                disp_data    = 32'h0;
            end
            if (i > 5 && !rot_busy) break;
        end
        chk("rot_len", busy_cnt[7:0], 8'(ROT_LEN));
        chk("rot_len_hi", busy_cnt[15:8], 8'(ROT_LEN >> 8));

        // Re-trigger mid-rotation is ignored; held level does not restart.
        disp_data    = 32'h1357_9BDF;
        disp_data_en = 1'b1;
        busy_cnt     = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (rot_busy) busy_cnt++;
            if (i == 1) disp_data_en = 1'b0;
            if (i == 100) disp_data_en = 1'b1;
            if (i > 5 && !rot_busy) break;
        end
        chk("retrig_len", busy_cnt[7:0], 8'(ROT_LEN));
        chk("retrig_len_hi", busy_cnt[15:8], 8'(ROT_LEN >> 8));
        run(50);
        chk("held_no_restart", {7'b0, rot_busy}, 8'h00);

        // Reset during rotation step 4.
        disp_data_en = 1'b0;
        step();
        disp_data    = 32'h8642_0975;
        disp_data_en = 1'b1;
        run(4 * STEP + 5);
        chk("rot_mid_busy", {7'b0, rot_busy}, 8'h01);
        rst = 1'b1;
        step();
        chk("rst_mid_busy", {7'b0, rot_busy}, 8'h00);
        chk("rst_mid_an", an, 8'hFF);
        chk("rst_mid_seg", seg, 8'hFF);
        rst          = 1'b0;
        disp_data_en = 1'b0;
        step();
        chk("resume_an", an, 8'hFE);
        run(40);

        // Randomised segments with occasional rotations and a reset.
        for (int it = 0; it < 30; it++) begin
            disp_data    = $urandom;
            edit_en      = 1'($urandom_range(0, 1));
            weishu       = 4'($urandom_range(0, 9));
            shuzi        = 4'($urandom_range(0, 15));
            disp_data_en = ($urandom_range(0, 3) == 0);
            rst          = (it == 15);
            hold         = int'($urandom_range(1, 60));
            run(hold);
            rst = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
